// File: rtl/cl_gen_pkg.sv
// Shared types for the Camera Link frame generator.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cl_gen_pkg;

    localparam int DEF_TAPS  = 2;
    localparam int TAP_SHIFT = $clog2(DEF_TAPS);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LEAD = 3'd1,
        LINE = 3'd2,
        HBL  = 3'd3,
        VBL  = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        PAT_HRAMP   = 2'd0,
        PAT_VRAMP   = 2'd1,
        PAT_CHECKER = 2'd2,
        PAT_DIAG    = 2'd3
    } pattern_e;

endpackage

// File: rtl/cl_pattern_gen.sv
// Maps pattern/column/line/frame to one beat of TAPS pixels, tap 0 in the LSBs.
// Latency: 1 cycle, so the beat lines up with the registered lval.
// Backpressure: none; output is forced to zero whenever en is low.
module cl_pattern_gen
    import cl_gen_pkg::*;
#(
    parameter int PIX_W = 12,
    parameter int TAPS  = DEF_TAPS,
    parameter int CNT_W = 16
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic                  en,
    input  pattern_e              pattern,
    input  logic [CNT_W-1:0]      col_base,
    input  logic [CNT_W-1:0]      line,
    input  logic [CNT_W-1:0]      frame,
    output logic [TAPS*PIX_W-1:0] pix_data
);

    // Arithmetic is done at the wider of the two widths, then truncated to PIX_W.
    localparam int VW = (PIX_W > CNT_W) ? PIX_W : CNT_W;

    logic [TAPS*PIX_W-1:0] pix_nxt;
    logic [VW-1:0]         col;
    logic [VW-1:0]         lin;
    logic [VW-1:0]         frm;
    logic [VW-1:0]         val;

    // Per-tap pixel value for the beat currently being emitted.
    always_comb begin
        pix_nxt = '0;
        col     = '0;
        lin     = VW'(line);
        frm     = VW'(frame);
        val     = '0;
        for (int t = 0; t < TAPS; t++) begin
            col = VW'(col_base) + VW'(t);
            case (pattern)
                PAT_HRAMP:   val = col;
                PAT_VRAMP:   val = lin;
                PAT_CHECKER: val = (col[3] ^ lin[3]) ? '1 : '0;
                default:     val = col + lin + frm;
            endcase
            pix_nxt[t*PIX_W +: PIX_W] = en ? val[PIX_W-1:0] : '0;
        end
    end

    // Register the beat so it appears together with lval/dval.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            pix_data <= '0;
        end else begin
            pix_data <= pix_nxt;
        end
    end

endmodule

// File: rtl/cl_frame_gen.sv
// Camera Link video source: FVAL/LVAL/DVAL plus multi-tap test-pattern pixels.
// Latency: outputs lag the internal state by 1 cycle; fval rises 1 cycle after start is taken.
// Backpressure: none; free-running once started, stop only ends at a frame boundary.
module cl_frame_gen
    import cl_gen_pkg::*;
#(
    parameter int PIX_W = 12,
    parameter int TAPS  = DEF_TAPS,
    parameter int CNT_W = 16
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  continuous,
    input  logic [CNT_W-1:0]      image_width,
    input  logic [CNT_W-1:0]      image_height,
    input  logic [CNT_W-1:0]      hblank,
    input  logic [CNT_W-1:0]      vblank,
    input  logic [1:0]            pattern_sel,
    output logic                  fval,
    output logic                  lval,
    output logic                  dval,
    output logic [TAPS*PIX_W-1:0] pix_data,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  cfg_err,
    output logic [CNT_W-1:0]      frame_cnt
);

    localparam int              SHIFT = $clog2(TAPS);
    localparam logic [CNT_W-1:0] ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [CNT_W-1:0] line, line_nxt;
    logic [CNT_W-1:0] sh_width, sh_height, sh_hblank, sh_vblank;
    pattern_e         sh_pat;
    logic             sh_cont;
    logic             stop_flag;
    logic             latch;
    logic             cfg_err_nxt;
    logic             done_nxt;
    logic             cfg_ok;
    logic [CNT_W-1:0] hb_len, vb_len, beats;
    logic [CNT_W-1:0] col_base;

    // Zero blanking is stretched to one cycle so the sync edges stay visible.
    assign hb_len   = (sh_hblank == '0) ? ONE : sh_hblank;
    assign vb_len   = (sh_vblank == '0) ? ONE : sh_vblank;
    assign beats    = sh_width >> SHIFT;
    assign col_base = cnt << SHIFT;
    assign cfg_ok   = (image_width != '0) && (image_height != '0) &&
                      ((image_width & CNT_W'(TAPS - 1)) == '0);

    // Next-state logic: cnt counts cycles within the current phase from zero.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt + ONE;
        line_nxt    = line;
        latch       = 1'b0;
        cfg_err_nxt = 1'b0;
        done_nxt    = 1'b0;
        case (state)
            IDLE: begin
                cnt_nxt  = '0;
                line_nxt = '0;
                if (start) begin
                    if (cfg_ok) begin
                        latch     = 1'b1;
                        state_nxt = LEAD;
                    end else begin
                        cfg_err_nxt = 1'b1;
                    end
                end
            end
            LEAD: begin
                if (cnt == hb_len - ONE) begin
                    state_nxt = LINE;
                    cnt_nxt   = '0;
                end
            end
            LINE: begin
                if (cnt == beats - ONE) begin
                    state_nxt = HBL;
                    cnt_nxt   = '0;
                end
            end
            HBL: begin
                if (cnt == hb_len - ONE) begin
                    cnt_nxt = '0;
                    if (line == sh_height - ONE) begin
                        state_nxt = VBL;
                        line_nxt  = '0;
                    end else begin
                        state_nxt = LINE;
                        line_nxt  = line + ONE;
                    end
                end
            end
            VBL: begin
                if (cnt == vb_len - ONE) begin
                    done_nxt = 1'b1;
                    cnt_nxt  = '0;
                    // A stop arriving on the very last blanking cycle still counts.
                    if (sh_cont && !stop_flag && !stop) begin
                        latch     = 1'b1;
                        state_nxt = LEAD;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
                line_nxt  = '0;
            end
        endcase
    end

    // State, counters, config shadow, sticky stop and registered status outputs.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state      <= IDLE;
            cnt        <= '0;
            line       <= '0;
            sh_width   <= '0;
            sh_height  <= '0;
            sh_hblank  <= '0;
            sh_vblank  <= '0;
            sh_pat     <= PAT_HRAMP;
            sh_cont    <= 1'b0;
            stop_flag  <= 1'b0;
            fval       <= 1'b0;
            lval       <= 1'b0;
            dval       <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            cfg_err    <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            line  <= line_nxt;
            if (latch) begin
                sh_width  <= image_width;
                sh_height <= image_height;
                sh_hblank <= hblank;
                sh_vblank <= vblank;
                sh_pat    <= pattern_e'(pattern_sel);
                sh_cont   <= continuous;
            end
            if (state == IDLE) begin
                stop_flag <= 1'b0;
            end else if (stop) begin
                stop_flag <= 1'b1;
            end
            fval       <= (state == LEAD) || (state == LINE) || (state == HBL);
            lval       <= (state == LINE);
            dval       <= (state == LINE);
            busy       <= (state != IDLE);
            frame_done <= done_nxt;
            cfg_err    <= cfg_err_nxt;
            if (done_nxt) begin
                frame_cnt <= frame_cnt + ONE;
            end
        end
    end

    cl_pattern_gen #(
        .PIX_W (PIX_W),
        .TAPS  (TAPS),
        .CNT_W (CNT_W)
    ) u_pattern (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .en       (state == LINE),
        .pattern  (sh_pat),
        .col_base (col_base),
        .line     (line),
        .frame    (frame_cnt),
        .pix_data (pix_data)
    );

endmodule

// File: doc/cl_frame_gen.md
Name: cl_frame_gen

Overview:
- Camera Link video source that emits FVAL/LVAL/DVAL and multi-tap pixel data on sys_clk with programmable geometry, blanking and test pattern.
- It is the transmitting end of the camera video interface. It drives the camera receiver's parallel input in loopback test mode and serves as a bench stimulus source for the DMA path.
- Configuration comes from the AXI4-Lite register bank (capture/width/height style fields).

Parameters:
- PIX_W, 12, bits per pixel per tap.
- TAPS, 2, pixels transferred per clock (1, 2 or 4).
- CNT_W, 16, width of geometry, blanking and frame counters.

Ports:
- sys_clk  in  1  single clock for all logic.
- sys_rst  in  1  reset, synchronous and active-high.
- start  in  1  one-cycle pulse; begins a frame when idle.
- stop  in  1  one-cycle pulse; finish the current frame, then go idle.
- continuous  in  1  when 1, back-to-back frames until stop.
- image_width  in  CNT_W  pixels per line.
- image_height  in  CNT_W  lines per frame.
- hblank  in  CNT_W  LVAL-low cycles before the first line and after every line.
- vblank  in  CNT_W  FVAL-low cycles after each frame.
- pattern_sel  in  2  0=h-ramp, 1=v-ramp, 2=checker, 3=moving diagonal.
- fval  out  1  frame valid.
- lval  out  1  line valid.
- dval  out  1  data valid (equals lval).
- pix_data  out  TAPS*PIX_W  tap 0 in LSBs.
- busy  out  1  high in any state other than IDLE.
- frame_done  out  1  one-cycle pulse at end of vblank.
- cfg_err  out  1  one-cycle pulse when start is rejected.
- frame_cnt  out  CNT_W  completed frames; wraps.

Behaviour:
- Reset: state=IDLE. All outputs are 0, including frame_cnt. Reset mid-frame forces fval/lval/dval/pix_data to 0 on the next edge, with no trailing vblank.
- All outputs are registered.
- States and transitions:
  - IDLE: start sampled high. If image_width==0, image_height==0 or image_width mod TAPS!=0, pulse cfg_err for one cycle and remain in IDLE. Otherwise latch all config into shadow registers, clear the stop flag and go to LEAD.
  - LEAD: fval=1, lval=0 for max(hblank,1) cycles, then LINE.
  - LINE: fval=lval=dval=1 for image_width/TAPS cycles, then HBL.
  - HBL: fval=1, lval=0 for max(hblank,1) cycles. Go to LINE if more lines remain, else VBL.
  - VBL: fval=0 for max(vblank,1) cycles. frame_done pulses and frame_cnt increments on the last VBL cycle. Next state is LEAD, with config re-latched, if the continuous shadow is set and no stop is pending; otherwise IDLE.
- Timing: start high at edge k (in IDLE, valid config) gives fval=1 from edge k+1 and first lval at edge k+1+max(hblank,1).
- FVAL high length = max(hblank,1) + image_height*(image_width/TAPS + max(hblank,1)) cycles.
- Input handling:
  - start is ignored while busy.
  - stop in any non-IDLE state sets a sticky flag; the current frame always completes. stop in IDLE has no effect.
  - start and stop in the same IDLE cycle: start wins and the flag is cleared.
  - Config inputs changing mid-frame have no effect until the next latch.
- Pixel value for tap t, beat b, line l (0-based), with col = b*TAPS+t and all results mod 2^PIX_W:
  - pattern 0: col.
  - pattern 1: l.
  - pattern 2: all ones if col[3]^l[3], else 0.
  - pattern 3: col + l + frame_cnt.
- pix_data=0 whenever dval=0.
- Counters are CNT_W wide; image_width/TAPS uses a shift (TAPS is a power of 2).

Decomposition:
- Package cl_gen_pkg holds the state enum (IDLE, LEAD, LINE, HBL, VBL), the pattern_e enum and the localparam TAP_SHIFT = $clog2(TAPS).
- One sub-module, cl_pattern_gen, maps (pattern, col base, line, frame_cnt) to TAPS*PIX_W pixel data, registered to align with lval.

Test Plan:
- TAPS=2, width=8, height=2, hblank=2, vblank=3, pattern 0, start pulse -> fval high 14 cycles, lval high 4 cycles ×2 with a 2-cycle gap, pix_data beats {1,0},{3,2},{5,4},{7,6} per line, frame_done 3 cycles after fval falls, frame_cnt=1, busy low after.
- width=7 with TAPS=2, start -> cfg_err one pulse, busy stays 0, fval never rises. Repeat with height=0 -> same response.
- continuous=1, pattern 3, two frames, then stop mid-frame 3 -> frame 3 completes fully, frame_cnt=3, IDLE. Line 0 col 0 value equals the frame index.
- hblank=0, vblank=0 -> treated as 1: lval gaps of exactly 1 cycle, fval low exactly 1 cycle between continuous frames.
- sys_rst asserted during LINE of line 1 -> next edge all outputs 0 and frame_cnt=0. A new start after reset yields a clean frame.
- Change image_width from 8 to 16 mid-frame with continuous=1 -> current frame keeps 4 beats/line, next frame has 8 beats/line. A start pulse while busy is ignored.
